// File: rtl/priority_encoder_rr.sv
// Registered N-input priority encoder with fixed or round-robin priority and
// a one-deep valid/ready result register.
module priority_encoder_rr #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rr_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic             out_none
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is high whenever the result register is empty or being drained
  // in the same cycle; no skid storage, so in_ready depends on out_ready.
  logic             accept;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] win_idx;
  logic [N-1:0]     win_oh;
  logic             any_req;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Each request gets a rank = distance below the start pointer, wrapping at
  // N (not 2^IDX_W); rank 0 is searched first, lowest ranked request wins.
  always_comb begin
    int best;
    int rank;
    best    = N;
    rank    = 0;
    start   = rr_en ? ptr : '0;
    win_idx = '0;
    win_oh  = '0;
    any_req = 1'b0;
    for (int j = 0; j < N; j++) begin
      rank = int'(start) + N - 1 - j;
      if (rank >= N) rank = rank - N;
      if (in_req[j] && (rank < best)) begin
        best       = rank;
        win_idx    = IDX_W'(j);
        win_oh     = '0;
        win_oh[j]  = 1'b1;
        any_req    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_none   <= 1'b0;
      ptr        <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_idx    <= win_idx;
      out_onehot <= win_oh;
      out_none   <= !any_req;
      // ptr follows every real grant in both modes so a mode switch stays fair
      if (any_req) ptr <= win_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/priority_encoder_rr.md
Name: priority_encoder_rr

Overview:
- Parametrised, registered priority encoder. Generalises the 4-to-2 combinational encoder to N requests with a one-cycle output register and a valid/ready handshake on both sides.
- Provides two priority modes, selectable at run time: fixed priority, where the highest index wins, and round-robin, where a rotating pointer sets the starting index.
- Sits between request-collection logic and a downstream consumer (arbiter grant path, interrupt controller).

Parameters:
- N, 8, number of request lines; legal range 2..64; need not be a power of two.
- IDX_W, $clog2(N), width of the encoded index; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rr_en  in  1  1 = round-robin mode, 0 = fixed priority; sampled on each accepted transfer
- in_valid  in  1  in_req is valid this cycle
- in_ready  out  1  block can accept in_req this cycle
- in_req  in  N  request vector; bit i = request i
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  consumer takes the result this cycle
- out_idx  out  IDX_W  encoded index of the winning request
- out_onehot  out  N  one-hot grant; all zero when there is no request
- out_none  out  1  accepted in_req was all zero (replaces the old "valid" flag, inverted)

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_idx=0, out_onehot=0, out_none=0, ptr=0.
  - in_ready=1 in the first cycle after release.
  - Reset asserted mid-transfer drops any pending result; no partial grant survives.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; one-deep pipe, no skid buffer).
  - Accept = in_valid && in_ready; the result register loads on the same clock edge.
  - Latency: exactly 1 cycle from accept to out_valid=1.
  - out_valid && !out_ready: out_idx, out_onehot and out_none hold stable; in_ready=0.
  - out_valid && out_ready && in_valid: back-to-back; new result loads, out_valid stays 1.
  - out_valid && out_ready && !in_valid: out_valid falls to 0 next cycle.
- Fixed priority (rr_en=0):
  - Winner is the highest set index of in_req (bit N-1 beats bit 0).
- Round-robin (rr_en=1):
  - Search order is ptr-1, ptr-2, ..., 0, N-1, ..., ptr (descending, wrapping at 0 to N-1).
  - With ptr=0 the order is N-1..0, identical to fixed priority.
  - Wrap uses N, not 2^IDX_W; indices ≥ N never appear.
- Pointer update:
  - On every accepted non-zero request, ptr <= winning index, in both modes.
  - A fixed-priority grant also moves ptr, so switching mode stays fair.
  - ptr changes on accept, not on output consumption.
- Zero request (in_req == 0):
  - Accepted normally; result is out_none=1, out_idx=0, out_onehot=0.
  - ptr unchanged. No X is ever driven on outputs.
- Outputs:
  - out_onehot always equals 1<<out_idx when out_none=0.
  - When out_valid=0, outputs hold their last value; consumers ignore them.
- X on in_req: no defined behaviour is required. Verification drives only known values.
- Implementation: combinational search plus a single register stage; no other storage besides ptr.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_n=0, release, drive nothing.
  - Required: out_valid=0, out_idx=0, out_none=0, in_ready=1.
- Fixed priority, N=8:
  - Stimulus: rr_en=0, send in_req=8'b0010_0110, out_ready=1.
  - Required: one cycle later out_valid=1, out_idx=5, out_onehot=8'b0010_0000.
  - Stimulus: sweep in_req 0..255.
  - Required: out_idx equals the highest set bit each time; in_req=0 gives out_none=1, out_idx=0.
- Round-robin rotation:
  - Stimulus: rr_en=1, send in_req=8'b1000_0101 four times back-to-back.
  - Required: grants 7, 2, 0, 7; ptr=7 at the end.
- Non-power-of-two wrap:
  - Stimulus: N=5, rr_en=1, in_req=5'b10001 repeatedly.
  - Required: grants alternate 4, 0, 4, 0; out_idx never reaches 5..7.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles after a result, with in_valid held high and in_req changing.
  - Required: in_ready=0 and outputs stable throughout.
  - Stimulus: raise out_ready.
  - Required: the held in_req is accepted; next result appears one cycle later.
- Async reset mid-stream:
  - Stimulus: assert rst_n=0 between clock edges while out_valid=1 and ptr=3.
  - Required: out_valid drops immediately without a clock edge; after release, a round-robin grant on in_req=8'hFF is 7 (ptr reset to 0).
